// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and entry layout for the multi-CDB reservation station
package rs_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int RS_FU_NUM  = 2;
    localparam int RS_CDB_NUM = 2;
    localparam int RS_VAL_W   = 64;
    localparam int RS_TAG_W   = 7;
    localparam int RS_CTRL_W  = 16;

    typedef struct packed {
        logic                rdy;
        logic [RS_TAG_W-1:0] tag;
        logic [RS_VAL_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                 valid;
        logic [RS_CTRL_W-1:0] ctrl;
        logic [RS_TAG_W-1:0]  dst_tag;
        rs_src_t              src1;
        rs_src_t              src2;
        logic [RS_VAL_W-1:0]  imm;
    } rs_entry_t;

endpackage

// File: rtl/rs_multi_cdb_station_age_matrix.sv
// rs_age_matrix: relative-age tracker returning an oldest-first rank for each requesting entry
module rs_age_matrix #(
    parameter  int ENTRIES = 8,
    localparam int RW      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ENTRIES-1:0]    i_alloc,
    input  logic [ENTRIES-1:0]    i_free,
    input  logic [ENTRIES-1:0]    i_req,
    output logic [ENTRIES*RW-1:0] o_rank
);

    logic [ENTRIES-1:0] r_live;
    logic [ENTRIES-1:0] r_older [ENTRIES];

    // Row i holds the entries older than i; a new row sees every surviving entry as older
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live <= '0;
            for (int i = 0; i < ENTRIES; i++) r_older[i] <= '0;
        end else begin
            r_live <= (r_live & ~i_free) | i_alloc;
            for (int i = 0; i < ENTRIES; i++)
                r_older[i] <= i_alloc[i] ? (r_live & ~i_free) :
                              (i_free[i] ? '0 : (r_older[i] & ~i_free & ~i_alloc));
        end
    end

    // Rank of a requester is the number of older requesters, so rank 0 is the oldest
    always_comb begin
        o_rank = '0;
        for (int i = 0; i < ENTRIES; i++)
            for (int j = 0; j < ENTRIES; j++)
                o_rank[i*RW +: RW] = o_rank[i*RW +: RW] + RW'(r_older[i][j] & i_req[j]);
    end

endmodule

// File: rtl/rs_multi_cdb_station.sv
// rs_multi_cdb_station: reservation station with multi-bus CDB wakeup and oldest-first multi-FU issue
module rs_multi_cdb_station
    import rs_pkg::*;
#(
    parameter  int ENTRIES = RS_ENTRIES,
    parameter  int FU_NUM  = RS_FU_NUM,
    parameter  int CDB_NUM = RS_CDB_NUM,
    parameter  int VAL_W   = RS_VAL_W,
    parameter  int TAG_W   = RS_TAG_W,
    parameter  int CTRL_W  = RS_CTRL_W,
    localparam int OCC_W   = $clog2(ENTRIES + 1),
    localparam int RW      = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [TAG_W-1:0]         in_dst_tag,
    input  logic [TAG_W-1:0]         in_src1_tag,
    input  logic                     in_src1_rdy,
    input  logic [VAL_W-1:0]         in_src1_val,
    input  logic [TAG_W-1:0]         in_src2_tag,
    input  logic                     in_src2_rdy,
    input  logic [VAL_W-1:0]         in_src2_val,
    input  logic [VAL_W-1:0]         in_imm,
    input  logic [CDB_NUM-1:0]       cdb_valid,
    input  logic [CDB_NUM*TAG_W-1:0] cdb_tag,
    input  logic [CDB_NUM*VAL_W-1:0] cdb_val,
    input  logic                     flush,
    input  logic [FU_NUM-1:0]        fu_ready,
    output logic [FU_NUM-1:0]        fu_valid,
    output logic [FU_NUM*CTRL_W-1:0] fu_ctrl,
    output logic [FU_NUM*TAG_W-1:0]  fu_dst_tag,
    output logic [FU_NUM*VAL_W-1:0]  fu_src1,
    output logic [FU_NUM*VAL_W-1:0]  fu_src2,
    output logic [FU_NUM*VAL_W-1:0]  fu_imm,
    output logic [OCC_W-1:0]         occupancy
);

    rs_entry_t             r_ent [ENTRIES];
    logic [OCC_W-1:0]      r_occ;
    logic [FU_NUM-1:0]     r_fu_valid;
    logic [FU_NUM*CTRL_W-1:0] r_fu_ctrl;
    logic [FU_NUM*TAG_W-1:0]  r_fu_dst;
    logic [FU_NUM*VAL_W-1:0]  r_fu_src1;
    logic [FU_NUM*VAL_W-1:0]  r_fu_src2;
    logic [FU_NUM*VAL_W-1:0]  r_fu_imm;

    rs_entry_t             w_new;
    logic                  w_alloc;
    logic [ENTRIES-1:0]    w_valid;
    logic [ENTRIES-1:0]    w_req;
    logic [ENTRIES-1:0]    w_free_oh;
    logic [ENTRIES-1:0]    w_disp;
    logic [ENTRIES*RW-1:0] w_rank;
    logic [FU_NUM-1:0]     w_gnt;
    logic [RW-1:0]         w_gnt_idx [FU_NUM];
    logic [OCC_W-1:0]      w_ngnt;

    // A waiting operand latches the value of the lowest-numbered bus carrying its tag
    function automatic rs_src_t wake(input rs_src_t s);
        wake = s;
        for (int k = CDB_NUM - 1; k >= 0; k--)
            if (!s.rdy && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s.tag) begin
                wake.rdy = 1'b1;
                wake.val = cdb_val[k*VAL_W +: VAL_W];
            end
    endfunction

    // Tag 0 is the zero register; other sources take the table value or a same-cycle CDB bypass
    function automatic rs_src_t capture(input logic [TAG_W-1:0] t, input logic r, input logic [VAL_W-1:0] v);
        rs_src_t s;
        s.rdy = r || (t == '0);
        s.tag = t;
        s.val = (t == '0) ? '0 : v;
        return wake(s);
    endfunction

    for (genvar g = 0; g < ENTRIES; g++) begin : g_flags
        assign w_valid[g] = r_ent[g].valid;
        assign w_req[g]   = r_ent[g].valid && r_ent[g].src1.rdy && r_ent[g].src2.rdy;
    end

    assign in_ready   = r_occ < OCC_W'(ENTRIES);
    assign w_alloc    = in_valid && in_ready && !flush;
    assign occupancy  = r_occ;
    assign fu_valid   = r_fu_valid;
    assign fu_ctrl    = r_fu_ctrl;
    assign fu_dst_tag = r_fu_dst;
    assign fu_src1    = r_fu_src1;
    assign fu_src2    = r_fu_src2;
    assign fu_imm     = r_fu_imm;

    // Build the incoming entry with zero-tag and bypass handling applied
    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.ctrl    = in_ctrl;
        w_new.dst_tag = in_dst_tag;
        w_new.src1    = capture(in_src1_tag, in_src1_rdy, in_src1_val);
        w_new.src2    = capture(in_src2_tag, in_src2_rdy, in_src2_val);
        w_new.imm     = in_imm;
    end

    // Lowest-index free slot; scanning downward leaves the lowest one set
    always_comb begin
        w_free_oh = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!w_valid[i]) begin
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
            end
    end

    rs_age_matrix #(.ENTRIES(ENTRIES)) u_age (
        .clk     (clk),
        .reset   (reset),
        .i_alloc (w_alloc ? w_free_oh : '0),
        .i_free  (flush ? '1 : w_disp),
        .i_req   (w_req),
        .o_rank  (w_rank)
    );

    // The p-th ready FU takes the candidate whose age rank is p
    always_comb begin
        int pos;
        pos    = 0;
        w_gnt  = '0;
        w_disp = '0;
        w_ngnt = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            w_gnt_idx[f] = '0;
            if (fu_ready[f]) begin
                for (int i = 0; i < ENTRIES; i++)
                    if (w_req[i] && int'(w_rank[i*RW +: RW]) == pos) begin
                        w_gnt[f]     = 1'b1;
                        w_gnt_idx[f] = RW'(i);
                        w_disp[i]    = 1'b1;
                        w_ngnt       = w_ngnt + OCC_W'(1);
                    end
                pos++;
            end
        end
    end

    // Entry array: flush squashes everything, otherwise allocate, wake and free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (flush) r_ent[i].valid <= 1'b0;
                else if (w_alloc && w_free_oh[i]) r_ent[i] <= w_new;
                else begin
                    r_ent[i].src1 <= wake(r_ent[i].src1);
                    r_ent[i].src2 <= wake(r_ent[i].src2);
                    if (w_disp[i]) r_ent[i].valid <= 1'b0;
                end
            end
        end
    end

    // Dispatch registers: strobe for one cycle, payload held when not granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fu_valid <= '0;
            r_fu_ctrl  <= '0;
            r_fu_dst   <= '0;
            r_fu_src1  <= '0;
            r_fu_src2  <= '0;
            r_fu_imm   <= '0;
        end else begin
            for (int f = 0; f < FU_NUM; f++) begin
                r_fu_valid[f] <= w_gnt[f] && !flush;
                if (w_gnt[f] && !flush) begin
                    r_fu_ctrl[f*CTRL_W +: CTRL_W] <= r_ent[w_gnt_idx[f]].ctrl;
                    r_fu_dst[f*TAG_W +: TAG_W]    <= r_ent[w_gnt_idx[f]].dst_tag;
                    r_fu_src1[f*VAL_W +: VAL_W]   <= r_ent[w_gnt_idx[f]].src1.val;
                    r_fu_src2[f*VAL_W +: VAL_W]   <= r_ent[w_gnt_idx[f]].src2.val;
                    r_fu_imm[f*VAL_W +: VAL_W]    <= r_ent[w_gnt_idx[f]].imm;
                end
            end
        end
    end

    // Occupancy tracks one allocation in and every grant out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_occ <= '0;
        else r_occ <= flush ? '0 : r_occ + OCC_W'(w_alloc) - w_ngnt;
    end

endmodule

// File: tb/tb_rs_multi_cdb_station.sv
// tb_rs_multi_cdb_station: scoreboard bench with a queue-based reference model of the station
module tb_rs_multi_cdb_station;

    logic         clk = 1'b0, reset = 1'b0;
    logic         in_valid = 1'b0, flush = 1'b0;
    logic         in_ready;
    logic [15:0]  in_ctrl = '0;
    logic [6:0]   in_dst_tag = '0, in_src1_tag = '0, in_src2_tag = '0;
    logic         in_src1_rdy = 1'b0, in_src2_rdy = 1'b0;
    logic [63:0]  in_src1_val = '0, in_src2_val = '0, in_imm = '0;
    logic [1:0]   cdb_valid = '0, fu_ready = '0;
    logic [13:0]  cdb_tag = '0;
    logic [127:0] cdb_val = '0;
    logic [1:0]   fu_valid;
    logic [31:0]  fu_ctrl;
    logic [13:0]  fu_dst_tag;
    logic [127:0] fu_src1, fu_src2, fu_imm;
    logic [3:0]   occupancy;

    rs_multi_cdb_station dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_dst_tag(in_dst_tag), .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
        .in_src1_val(in_src1_val), .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy),
        .in_src2_val(in_src2_val), .in_imm(in_imm), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .flush(flush), .fu_ready(fu_ready), .fu_valid(fu_valid),
        .fu_ctrl(fu_ctrl), .fu_dst_tag(fu_dst_tag), .fu_src1(fu_src1), .fu_src2(fu_src2),
        .fu_imm(fu_imm), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ctrl; logic [6:0] dst;
        logic r1; logic [6:0] t1; logic [63:0] v1;
        logic r2; logic [6:0] t2; logic [63:0] v2;
        logic [63:0] imm;
    } ment_t;
    typedef struct { int cyc; int fu; logic [15:0] ctrl; logic [6:0] dst; logic [63:0] s1, s2, imm; } exp_t;
    typedef struct { int cyc; int occ; } occ_t;

    ment_t mq[$];
    exp_t  fq[$];
    occ_t  oq[$];
    int    cyc = 0, n_chk = 0, n_fail = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic bit hit(input logic [6:0] t, output logic [63:0] v);
        v = '0;
        for (int k = 0; k < 2; k++)
            if (cdb_valid[k] && cdb_tag[k*7 +: 7] == t) begin
                v = cdb_val[k*64 +: 64];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    // Model of one clock edge: oldest ready entries to ready FUs in index order, then wakeup, then append
    task automatic model_step();
        int    n = cyc + 1;
        bit    acc = in_valid && mq.size() < 8;
        int    fl[$];
        ment_t keep[$];
        int    k = 0;
        if (flush) mq.delete();
        else begin
            for (int f = 0; f < 2; f++) if (fu_ready[f]) fl.push_back(f);
            foreach (mq[i]) begin
                if (mq[i].r1 && mq[i].r2 && k < fl.size()) begin
                    fq.push_back('{n, fl[k], mq[i].ctrl, mq[i].dst, mq[i].v1, mq[i].v2, mq[i].imm});
                    k++;
                end else keep.push_back(mq[i]);
            end
            foreach (keep[i]) begin
                logic [63:0] v;
                if (!keep[i].r1 && hit(keep[i].t1, v)) begin keep[i].r1 = 1'b1; keep[i].v1 = v; end
                if (!keep[i].r2 && hit(keep[i].t2, v)) begin keep[i].r2 = 1'b1; keep[i].v2 = v; end
            end
            mq = keep;
            if (acc) begin
                ment_t e;
                logic [63:0] v;
                e.ctrl = in_ctrl; e.dst = in_dst_tag; e.imm = in_imm;
                e.t1 = in_src1_tag; e.t2 = in_src2_tag;
                e.r1 = in_src1_tag == 0 || in_src1_rdy;
                e.v1 = (in_src1_tag != 0 && in_src1_rdy) ? in_src1_val : 64'd0;
                e.r2 = in_src2_tag == 0 || in_src2_rdy;
                e.v2 = (in_src2_tag != 0 && in_src2_rdy) ? in_src2_val : 64'd0;
                if (!e.r1 && hit(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
                if (!e.r2 && hit(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
                mq.push_back(e);
            end
        end
        oq.push_back('{n, mq.size()});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; cdb_valid = '0;
    endtask

    task automatic put(input logic [6:0] d, input logic [6:0] t1, input logic r1, input logic [63:0] v1,
                       input logic [6:0] t2, input logic r2, input logic [63:0] v2);
        in_valid = 1'b1; in_ctrl = 16'($urandom); in_imm = {$urandom, $urandom}; in_dst_tag = d;
        in_src1_tag = t1; in_src1_rdy = r1; in_src1_val = v1;
        in_src2_tag = t2; in_src2_rdy = r2; in_src2_val = v2;
    endtask

    // Monitor: match every strobe against the expectation queued for this edge
    always @(negedge clk) if (mon_en) begin
        for (int f = 0; f < 2; f++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < fq.size(); i++) if (idx < 0 && fq[i].cyc == cyc && fq[i].fu == f) idx = i;
            if (idx >= 0 || fu_valid[f]) begin
                chk($sformatf("fu%0d_valid@%0d", f, cyc), fu_valid[f], idx >= 0);
                if (idx >= 0) begin
                    if (fu_valid[f]) begin
                        chk($sformatf("fu%0d_ctrl@%0d", f, cyc), fu_ctrl[f*16 +: 16], fq[idx].ctrl);
                        chk($sformatf("fu%0d_dst@%0d", f, cyc), fu_dst_tag[f*7 +: 7], fq[idx].dst);
                        chk($sformatf("fu%0d_src1@%0d", f, cyc), fu_src1[f*64 +: 64], fq[idx].s1);
                        chk($sformatf("fu%0d_src2@%0d", f, cyc), fu_src2[f*64 +: 64], fq[idx].s2);
                        chk($sformatf("fu%0d_imm@%0d", f, cyc), fu_imm[f*64 +: 64], fq[idx].imm);
                    end
                    fq.delete(idx);
                end
            end
        end
        if (oq.size() > 0 && oq[0].cyc == cyc) begin
            chk($sformatf("occupancy@%0d", cyc), occupancy, oq[0].occ);
            chk($sformatf("in_ready@%0d", cyc), in_ready, oq[0].occ < 8);
            void'(oq.pop_front());
        end
    end

    initial begin
        #3;
        chk("reset_fu_valid", fu_valid, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_payload", {fu_ctrl, fu_dst_tag, fu_src1[63:0]}, 0);
        #9 reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        fu_ready = 2'b11;
        put(7'd3, 7'd2, 1'b1, 64'd15, 7'd1, 1'b1, 64'd9); step();
        idle(); repeat (3) step();
        put(7'd4, 7'd3, 1'b0, 64'd0, 7'd0, 1'b1, 64'd99); step();
        idle(); repeat (2) step();
        cdb_valid = 2'b10; cdb_tag = {7'd3, 7'd0}; cdb_val = {64'd24, 64'd0}; step();
        idle(); repeat (3) step();
        put(7'd6, 7'd0, 1'b0, 64'd0, 7'd5, 1'b0, 64'd0);
        cdb_valid = 2'b01; cdb_tag = {7'd0, 7'd5}; cdb_val = {64'd0, 64'd7}; step();
        idle(); repeat (3) step();
        fu_ready = 2'b00;
        for (int i = 0; i < 9; i++) begin put(7'(i + 10), 7'd1, 1'b1, 64'(i), 7'd2, 1'b1, 64'(i * 3)); step(); end
        idle(); fu_ready = 2'b11; repeat (5) step();
        fu_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin put(7'(i + 20), 7'd0, 1'b1, 64'd0, 7'd4, 1'b1, 64'(i)); step(); end
        put(7'd30, 7'd1, 1'b1, 64'd1, 7'd1, 1'b1, 64'd2); flush = 1'b1; step();
        idle(); fu_ready = 2'b11; repeat (3) step();
        fu_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin put(7'(i + 40), 7'd1, 1'b1, 64'(i + 1), 7'd2, 1'b1, 64'd5); step(); end
        idle(); fu_ready = 2'b11; step();
        mon_en = 1'b0;
        chk("pre_reset_fu_valid", fu_valid, 2'b11);
        #2 reset = 1'b0;
        #1;
        chk("async_fu_valid", fu_valid, 0);
        chk("async_occupancy", occupancy, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_payload", fu_src1, 0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        mq.delete(); fq.delete(); oq.delete();
        mon_en = 1'b1;
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 3) != 0)
                put(7'($urandom_range(1, 100)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            else in_valid = 1'b0;
            cdb_valid = 2'($urandom);
            cdb_tag = {7'($urandom_range(1, 7)), 7'($urandom_range(1, 7))};
            cdb_val = {$urandom, $urandom, $urandom, $urandom};
            fu_ready = 2'($urandom);
            flush = $urandom_range(0, 49) == 0;
            step();
        end
        idle(); fu_ready = 2'b11; repeat (4) step();
        @(negedge clk); #1;
        chk("scoreboard_drained", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
